// File: rtl/pll_mon_pkg.sv
// pll_mon_pkg: shared state encoding and counter widths for the PLL lock monitor.
package pll_mon_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;
    localparam int EDGE_CNT_W = 4;
    localparam int LOSS_CNT_W = 8;
    typedef logic [EDGE_CNT_W-1:0] edge_cnt_t;
    typedef logic [EDGE_CNT_W:0]   edge_sum_t;
    typedef logic [LOSS_CNT_W-1:0] loss_cnt_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchroniser with a delayed copy for toggle detection.
module sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] sync,
    output logic [W-1:0] tgl
);
    logic [W-1:0] meta_q, meta_d, sync_q, sync_d, dly_q, dly_d;
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end
    assign sync = sync_q;
    assign tgl  = sync_q ^ dly_q;
endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: qualifies PLL lock, checks per-output activity per window, counts lock losses.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int N_CH          = 6,
    parameter int WINDOW_LOG2   = 20,
    parameter int MIN_TOGGLES   = 2,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_LOCKED,
    input  logic [N_CH-1:0]       I_CNT,
    output logic                  O_STABLE,
    output logic [N_CH-1:0]       O_ALIVE,
    output logic                  O_ERR,
    output logic [LOSS_CNT_W-1:0] O_LOSS_CNT
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    typedef logic [SW-1:0]          settle_t;
    typedef logic [WINDOW_LOG2-1:0] win_t;
    localparam edge_sum_t MIN_T     = edge_sum_t'(MIN_TOGGLES);
    localparam settle_t   SETTLE_LAST = settle_t'(SETTLE_CYCLES - 1);

    logic                        locked_s, locked_tgl_unused;
    logic [N_CH-1:0]             cnt_tgl, cnt_sync_unused;
    state_t                      state_q, state_d;
    settle_t                     settle_q, settle_d;
    win_t                        win_q, win_d;
    logic [N_CH-1:0][EDGE_CNT_W-1:0] ecnt_q, ecnt_d;
    logic [N_CH-1:0]             alive_q, alive_d;
    logic                        first_q, first_d, err_q, err_d;
    loss_cnt_t                   loss_q, loss_d;
    logic                        run, settle_done, enter_run, loss, wrap;
    edge_sum_t                   sum;

    sync_edge #(.W(1)) u_sync_locked (
        .clk(CLK), .rst(RST), .d_in(I_LOCKED), .sync(locked_s), .tgl(locked_tgl_unused)
    );
    sync_edge #(.W(N_CH)) u_sync_cnt (
        .clk(CLK), .rst(RST), .d_in(I_CNT), .sync(cnt_sync_unused), .tgl(cnt_tgl)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = locked_s ? SETTLE : IDLE;
            SETTLE:  state_d = !locked_s ? IDLE : settle_done ? RUN : SETTLE;
            RUN:     state_d = locked_s ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run         = state_q == RUN;
        settle_done = settle_q == SETTLE_LAST;
        enter_run   = state_q == SETTLE && locked_s && settle_done;
        loss        = run && !locked_s;
        wrap        = run && locked_s && &win_q;
    end

    // Lock loss takes priority over a coinciding window close.
    always_comb begin
        settle_d = state_q == SETTLE ? settle_q + settle_t'(1) : '0;
        win_d    = run ? win_q + win_t'(1) : '0;
        ecnt_d   = ecnt_q;
        alive_d  = alive_q;
        sum      = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum        = edge_sum_t'(ecnt_q[i]) + edge_sum_t'(cnt_tgl[i]);
            ecnt_d[i]  = (!run || wrap) ? '0 :
                         &ecnt_q[i] ? ecnt_q[i] : ecnt_q[i] + edge_cnt_t'(cnt_tgl[i]);
            alive_d[i] = loss ? 1'b0 : wrap ? sum >= MIN_T : alive_q[i];
        end
        first_d = enter_run ? 1'b0 : wrap ? 1'b1 : first_q;
        loss_d  = (loss && loss_q != '1) ? loss_q + loss_cnt_t'(1) : loss_q;
        err_d   = run && first_q && !(&alive_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            settle_q <= '0;
            win_q    <= '0;
            ecnt_q   <= '0;
            alive_q  <= '0;
            first_q  <= 1'b0;
            loss_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            settle_q <= settle_d;
            win_q    <= win_d;
            ecnt_q   <= ecnt_d;
            alive_q  <= alive_d;
            first_q  <= first_d;
            loss_q   <= loss_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        O_STABLE   = run;
        O_ALIVE    = alive_q;
        O_ERR      = err_q;
        O_LOSS_CNT = loss_q;
    end
endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: table-driven directed test of lock qualification, activity windows and loss counting.
module tb_pll_lock_monitor;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       I_LOCKED = 1'b0;
    logic [5:0] I_CNT = '0;
    logic       O_STABLE;
    logic [5:0] O_ALIVE;
    logic       O_ERR;
    logic [7:0] O_LOSS_CNT;
    logic [5:0] cnt_en = 6'h3F;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic       lk;
        logic [5:0] en;
        int         w;
        logic       st;
        logic [5:0] al;
        logic       er;
        logic [7:0] ls;
    } vec_t;
    vec_t tv[17];

    pll_lock_monitor #(
        .N_CH(6), .WINDOW_LOG2(6), .MIN_TOGGLES(2), .SETTLE_CYCLES(16)
    ) dut (
        .CLK(CLK), .RST(RST), .I_LOCKED(I_LOCKED), .I_CNT(I_CNT),
        .O_STABLE(O_STABLE), .O_ALIVE(O_ALIVE), .O_ERR(O_ERR), .O_LOSS_CNT(O_LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        forever begin
            repeat (4) @(negedge CLK);
            I_CNT = I_CNT ^ cnt_en;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [5:0] al,
                           input logic er, input logic [7:0] ls);
        chk({tag, " stable"}, 32'(O_STABLE), 32'(st));
        chk({tag, " alive"}, 32'(O_ALIVE), 32'(al));
        chk({tag, " err"}, 32'(O_ERR), 32'(er));
        chk({tag, " loss"}, 32'(O_LOSS_CNT), 32'(ls));
    endtask

    initial begin
        tv[0]  = '{1'b1, 6'h3F, 18, 1'b0, 6'h00, 1'b0, 8'd0};
        tv[1]  = '{1'b1, 6'h3F,  1, 1'b1, 6'h00, 1'b0, 8'd0};
        tv[2]  = '{1'b1, 6'h3F, 63, 1'b1, 6'h00, 1'b0, 8'd0};
        tv[3]  = '{1'b1, 6'h3F,  1, 1'b1, 6'h3F, 1'b0, 8'd0};
        tv[4]  = '{1'b1, 6'h3F,  1, 1'b1, 6'h3F, 1'b0, 8'd0};
        tv[5]  = '{1'b1, 6'h37, 62, 1'b1, 6'h3F, 1'b0, 8'd0};
        tv[6]  = '{1'b1, 6'h37,  1, 1'b1, 6'h37, 1'b0, 8'd0};
        tv[7]  = '{1'b1, 6'h37,  1, 1'b1, 6'h37, 1'b1, 8'd0};
        tv[8]  = '{1'b0, 6'h37,  4, 1'b0, 6'h00, 1'b0, 8'd1};
        tv[9]  = '{1'b1, 6'h37, 19, 1'b1, 6'h00, 1'b0, 8'd1};
        tv[10] = '{1'b0, 6'h37,  4, 1'b0, 6'h00, 1'b0, 8'd2};
        tv[11] = '{1'b1, 6'h37, 19, 1'b1, 6'h00, 1'b0, 8'd2};
        tv[12] = '{1'b0, 6'h37,  4, 1'b0, 6'h00, 1'b0, 8'd3};
        tv[13] = '{1'b1, 6'h37, 10, 1'b0, 6'h00, 1'b0, 8'd3};
        tv[14] = '{1'b0, 6'h37,  6, 1'b0, 6'h00, 1'b0, 8'd3};
        tv[15] = '{1'b1, 6'h37, 18, 1'b0, 6'h00, 1'b0, 8'd3};
        tv[16] = '{1'b1, 6'h37,  1, 1'b1, 6'h00, 1'b0, 8'd3};

        I_LOCKED = 1'b1;
        repeat (5) @(negedge CLK);
        chk_all("reset", 1'b0, 6'h00, 1'b0, 8'd0);
        RST = 1'b0;

        for (int i = 0; i < 17; i++) begin
            I_LOCKED = tv[i].lk;
            cnt_en   = tv[i].en;
            repeat (tv[i].w) @(negedge CLK);
            chk_all($sformatf("vec%0d", i), tv[i].st, tv[i].al, tv[i].er, tv[i].ls);
        end

        // 257 further losses take the total to 260; the counter must stop at 255.
        for (int i = 1; i <= 257; i++) begin
            I_LOCKED = 1'b0;
            repeat (4) @(negedge CLK);
            if (i == 252) chk("loss at 255", 32'(O_LOSS_CNT), 32'd255);
            I_LOCKED = 1'b1;
            repeat (20) @(negedge CLK);
        end
        chk("loss saturated", 32'(O_LOSS_CNT), 32'd255);
        cnt_en = 6'h3F;
        repeat (70) @(negedge CLK);
        chk_all("pre-rst run", 1'b1, 6'h3F, 1'b0, 8'd255);

        RST = 1'b1;
        @(negedge CLK);
        chk_all("mid-run rst", 1'b0, 6'h00, 1'b0, 8'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (79) @(negedge CLK);
        chk_all("before wrap", 1'b1, 6'h00, 1'b0, 8'd0);
        @(negedge CLK);
        I_LOCKED = 1'b0;
        repeat (3) @(negedge CLK);
        chk("wrap-drop stable", 32'(O_STABLE), 32'd0);
        chk("wrap-drop alive", 32'(O_ALIVE), 32'd0);
        chk("wrap-drop loss", 32'(O_LOSS_CNT), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
